// File: rtl/uart_cmd_parser.sv
// UART command framer for the AWG: parses A5-headed packets, streams samples to RAM, drives run and ACK/NAK.
// Optional build macro UART_CMD_TIMEOUT_EN adds an inter-byte timeout that silently abandons stalled packets.
module uart_cmd_parser #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 16,
  parameter int TIMEOUT_CLKS = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              run,
  output logic              busy
);

  localparam logic [7:0] HDR       = 8'hA5;
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_RUN   = 8'h02;
  localparam logic [7:0] CMD_PING  = 8'h03;
  localparam logic [7:0] ACK       = 8'h06;
  localparam logic [7:0] NAK       = 8'h15;

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_ADDR_H, S_ADDR_L, S_COUNT, S_DATA_H, S_DATA_L,
    S_ARG, S_CHK, S_RESP_SEND, S_RESP_WAIT
  } state_t;

  state_t      state, state_d;
  logic [7:0]  chk_q, cmd_q, addr_h_q, data_h_q;
  logic        arg_q;
  logic [8:0]  remain_q;
  logic        timeout_hit;
  logic        in_packet;

  assign in_packet = (state != S_IDLE) && (state != S_RESP_SEND) && (state != S_RESP_WAIT);
  assign tx_valid  = (state == S_RESP_SEND);
  assign busy      = (state != S_IDLE);

`ifdef UART_CMD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CLKS + 1);
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      to_cnt <= '0;
    else if (rx_valid || !in_packet) to_cnt <= '0;
    else if (!timeout_hit)           to_cnt <= to_cnt + TO_W'(1);
  end

  assign timeout_hit = in_packet && (to_cnt == TO_W'(TIMEOUT_CLKS));
`else
  // Never fires; TIMEOUT_CLKS only has meaning when the timeout is built.
  assign timeout_hit = (TIMEOUT_CLKS < 0);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:      if (rx_valid && rx_data == HDR) state_d = S_CMD;
      S_CMD:
        if (rx_valid) begin
          case (rx_data)
            CMD_WRITE: state_d = S_ADDR_H;
            CMD_RUN:   state_d = S_ARG;
            CMD_PING:  state_d = S_CHK;
            default:   state_d = S_RESP_SEND;
          endcase
        end
      S_ADDR_H:    if (rx_valid) state_d = S_ADDR_L;
      S_ADDR_L:    if (rx_valid) state_d = S_COUNT;
      S_COUNT:     if (rx_valid) state_d = S_DATA_H;
      S_DATA_H:    if (rx_valid) state_d = S_DATA_L;
      S_DATA_L:    if (rx_valid) state_d = (remain_q == 9'd1) ? S_CHK : S_DATA_H;
      S_ARG:       if (rx_valid) state_d = S_CHK;
      S_CHK:       if (rx_valid) state_d = S_RESP_SEND;
      S_RESP_SEND: state_d = S_RESP_WAIT;
      S_RESP_WAIT: if (tx_done) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
    if (timeout_hit) state_d = S_IDLE;
  end

  // Datapath: bytes are consumed only on rx_valid; the address advances right after each write pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chk_q     <= '0;
      cmd_q     <= '0;
      addr_h_q  <= '0;
      data_h_q  <= '0;
      arg_q     <= 1'b0;
      remain_q  <= '0;
      tx_data   <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      run       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (mem_we) mem_addr <= mem_addr + ADDR_W'(1);
      if (rx_valid && !timeout_hit) begin
        if (in_packet && state != S_CHK) chk_q <= chk_q ^ rx_data;
        case (state)
          S_IDLE: if (rx_data == HDR) chk_q <= '0;
          S_CMD: begin
            cmd_q <= rx_data;
            if (rx_data != CMD_WRITE && rx_data != CMD_RUN && rx_data != CMD_PING) tx_data <= NAK;
          end
          S_ADDR_H: addr_h_q <= rx_data;
          S_ADDR_L: mem_addr <= ADDR_W'({addr_h_q, rx_data});
          S_COUNT:  remain_q <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
          S_DATA_H: data_h_q <= rx_data;
          S_DATA_L: begin
            mem_we    <= 1'b1;
            mem_wdata <= DATA_W'({data_h_q, rx_data});
            remain_q  <= remain_q - 9'd1;
          end
          S_ARG: arg_q <= rx_data[0];
          S_CHK: begin
            if (rx_data == chk_q) begin
              tx_data <= ACK;
              if (cmd_q == CMD_RUN) run <= arg_q;
            end else begin
              tx_data <= NAK;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
Sits directly downstream of the UART receiver and upstream of the UART transmitter in the AWG control path. Frames the raw received byte stream into command packets and streams waveform samples into the sample RAM write port. Drives the generator run-enable and returns a one-byte ACK/NAK per packet through the transmitter handshake.

Parameters:
ADDR_W, 10, sample RAM address width; packet addresses are truncated to their low ADDR_W bits.
DATA_W, 16, sample width; each sample is carried as 2 bytes, big-endian, and the low DATA_W bits are used.
TIMEOUT_CLKS, 100000, maximum idle clocks between bytes inside a packet (only with the optional feature).

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-low reset.
rx_data  in  8  received byte, valid while rx_valid is high.
rx_valid  in  1  one-cycle strobe per received byte.
tx_data  out  8  response byte to the transmitter.
tx_valid  out  1  one-cycle start strobe to the transmitter.
tx_done  in  1  one-cycle strobe from the transmitter when its stop bit is complete.
mem_we  out  1  sample RAM write enable, one cycle per sample.
mem_addr  out  ADDR_W  sample RAM write address.
mem_wdata  out  DATA_W  sample RAM write data.
run  out  1  generator run-enable register.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: the FSM enters IDLE. All outputs are 0, including tx_data, mem_addr, mem_wdata and run. The checksum register is cleared.
- Packet format: 0xA5, CMD, args, CHK. CHK is the XOR of CMD and all argument bytes; the header is excluded.
- CMD 0x01 WRITE: ADDR_H, ADDR_L, N, then N samples of 2 bytes each. N=0 means 256 samples.
- CMD 0x02 RUN: one byte ARG; run is loaded with ARG[0].
- CMD 0x03 PING: no arguments.
- States: IDLE, CMD, ADDR_H, ADDR_L, COUNT, DATA_H, DATA_L, ARG, CHK, RESP_SEND, RESP_WAIT. The FSM advances only on rx_valid.
- IDLE: any byte other than 0xA5 is discarded. On 0xA5 the checksum is cleared and the FSM goes to CMD.
- CMD: a valid CMD goes to its first argument state (ADDR_H, ARG, or CHK for PING). An unknown CMD loads NAK and goes straight to RESP_SEND.
- DATA_L: mem_wdata is the concatenation of the DATA_H and DATA_L bytes. mem_we pulses in the cycle after the DATA_L byte strobe.
- mem_addr starts at the packet address and increments after each write. It wraps modulo 2^ADDR_W.
- After the Nth sample the FSM goes to CHK.
- Sample writes are committed as they arrive. A bad checksum does not roll them back; the host resends on NAK.
- CHK: if the byte equals the running XOR, tx_data=0x06 (ACK) and a RUN command applies ARG[0] to run in the same cycle. Otherwise tx_data=0x15 (NAK) and run is unchanged.
- RESP_SEND: tx_valid is high for exactly one cycle, then the FSM goes to RESP_WAIT.
- RESP_WAIT: stays until tx_done, then returns to IDLE.
- Any rx_valid in RESP_SEND or RESP_WAIT is dropped.
- If rx_valid and tx_done coincide in RESP_WAIT, the FSM returns to IDLE and the byte is dropped.
- Reset asserted mid-packet aborts immediately. run returns to 0 and any partial write burst is abandoned.
- Max latency from the CHK byte strobe to tx_valid: 2 clocks.

Optional Feature:
Macro: UART_CMD_TIMEOUT_EN.
- Defined: a counter clears on every rx_valid and counts in states CMD through CHK. When it reaches TIMEOUT_CLKS, the FSM returns to IDLE silently, with no response and run unchanged.
- Not defined: the counter logic is not built, and a stalled packet waits indefinitely for its next byte.

Test Plan:
- PING: send A5 03 03 -> tx_valid pulses once with tx_data=0x06; after tx_done, busy=0.
- RUN: send A5 02 01 03 -> ACK 0x06 and run=1. Then send A5 02 00 02 -> ACK and run=0.
- WRITE: send A5 01 00 10 02 12 34 AB CD 53 -> two mem_we pulses: addr 0x010 = 0x1234, then addr 0x011 = 0xABCD; then ACK.
- Bad checksum, wrap and unknown CMD:
  - A5 02 01 FF -> NAK 0x15, run stays 0.
  - A WRITE starting at address 0x3FF with N=2 -> writes to 0x3FF then 0x000.
  - A5 7E -> NAK.
- Timeout and reset (with UART_CMD_TIMEOUT_EN): send A5 01 00, then idle TIMEOUT_CLKS+5 clocks -> busy falls with no tx_valid, and a following PING is ACKed. Assert reset mid-WRITE -> all outputs return to 0 asynchronously.
